// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Shares one combinational ALU between two requesters. A round-robin
//   arbiter grants one requester in IDLE, the operation is latched, and one
//   (ADD/SUB/AND) or two (MUL/DIVMOD) ALU commands are sequenced before a
//   single 30-bit response is offered.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
//   clock edge where both valid and ready are high. A producer keeps valid and
//   its payload stable until that edge. Ready may depend combinationally on
//   valid. The response channel holds rsp_* stable until the transfer.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   reqN_valid/op/a/b          request from requester N (N = 0, 1)
//   reqN_ready                 accept strobe; at most one is high per cycle
//   rsp_valid/ready/id/data/err  response channel
//   busy                       high whenever the scheduler is not IDLE
//   alu_A, alu_B, alu_command  registered operands/command to the ALU
//   alu_res                    combinational ALU result
module alu_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [29:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [2:0]  alu_command,
  input  logic [14:0] alu_res
);

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;

  localparam logic [2:0] OP_MUL    = 3'd3;
  localparam logic [2:0] OP_DIVMOD = 3'd4;

  localparam logic [2:0] CMD_MUL_HI = 3'd4;
  localparam logic [2:0] CMD_REM    = 3'd5;
  localparam logic [2:0] CMD_QUOT   = 3'd6;

  state_t      state, state_nxt;
  logic        last_grant;
  logic [2:0]  op_q;
  logic [14:0] first_q;   // first-phase result (MUL low half or quotient)

  logic        accept;
  logic        grant1;
  logic [2:0]  sel_op;
  logic [15:0] sel_a, sel_b;
  logic        sel_err;
  logic [2:0]  first_cmd;
  logic        two_phase;

  // Grant: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_grant);
    accept     = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant1;
    req1_ready = accept && grant1;
    sel_op     = grant1 ? req1_op : req0_op;
    sel_a      = grant1 ? req1_a  : req0_a;
    sel_b      = grant1 ? req1_b  : req0_b;
    // Divisor zero means b[15:1] all clear; the ALU never sees such a divide.
    sel_err    = (sel_op > OP_DIVMOD) ||
                 ((sel_op == OP_DIVMOD) && (sel_b[15:1] == 15'd0));
    first_cmd  = (sel_op == OP_DIVMOD) ? CMD_QUOT : sel_op;
    two_phase  = (op_q == OP_MUL) || (op_q == OP_DIVMOD);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = sel_err ? RESP : EXEC1;
      EXEC1:   state_nxt = two_phase ? EXEC2 : RESP;
      EXEC2:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= 1'b1;
      op_q        <= 3'd0;
      first_q     <= 15'd0;
      alu_A       <= 16'd0;
      alu_B       <= 16'd0;
      alu_command <= 3'd0;
      rsp_id      <= 1'b0;
      rsp_data    <= 30'd0;
      rsp_err     <= 1'b0;
    end else begin
      // Command is registered so it is valid for the whole EXEC cycle and
      // returns to 0 everywhere else.
      alu_command <= 3'd0;
      if (state == IDLE && state_nxt == EXEC1)
        alu_command <= first_cmd;
      else if (state == EXEC1 && state_nxt == EXEC2)
        alu_command <= (op_q == OP_MUL) ? CMD_MUL_HI : CMD_REM;

      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= sel_op;
            alu_A      <= sel_a;
            alu_B      <= sel_b;
            rsp_id     <= grant1;
            last_grant <= grant1;
            rsp_err    <= sel_err;
            rsp_data   <= 30'd0;
          end
        end
        EXEC1: begin
          first_q <= alu_res;
          if (!two_phase) rsp_data <= {15'd0, alu_res};
        end
        EXEC2: begin
          // MUL packs {high, low}; DIVMOD packs {quotient, remainder}.
          if (op_q == OP_MUL) rsp_data <= {alu_res, first_q};
          else                rsp_data <= {first_q, alu_res};
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler
//   Drives alu_scheduler with directed requests through two requester
//   drivers, supplies a stand-in ALU, and checks every cycle against a
//   transaction-level model (grant rule, latency counts, expected response
//   queue), plus hand-computed literal results.
module tb_alu_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [29:0] rsp_data;
  logic [15:0] alu_A, alu_B;
  logic [2:0]  alu_command;
  logic [14:0] alu_res;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- stand-in ALU (magnitudes only) ----------------
  function automatic logic [14:0] alu_ref(input logic [2:0] c, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [13:0] ma, mb;
    logic [27:0] p;
    logic [14:0] r;
    ma = a[14:1];
    mb = b[14:1];
    p  = 28'(ma) * 28'(mb);
    case (c)
      3'd0: r = 15'(ma) + 15'(mb);
      3'd1: r = 15'(ma) - 15'(mb);
      3'd2: r = {1'b0, ma & mb};
      3'd3: r = p[14:0];
      3'd4: r = {2'b0, p[27:15]};
      3'd5: r = (mb == 14'd0) ? 15'h7fff : 15'(ma % mb);
      3'd6: r = (mb == 14'd0) ? 15'h7fff : 15'(ma / mb);
      default: r = 15'd0;
    endcase
    return r;
  endfunction

  assign alu_res = alu_ref(alu_command, alu_A, alu_B);

  alu_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .alu_A(alu_A), .alu_B(alu_B), .alu_command(alu_command), .alu_res(alu_res)
  );

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- requester drivers ----------------
  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } txn_t;

  txn_t rq0[$];
  txn_t rq1[$];
  logic took0 = 1'b0;
  logic took1 = 1'b0;

  task automatic push_req(input int id, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    txn_t t;
    t = '{op: op, a: a, b: b};
    if (id == 0) rq0.push_back(t);
    else         rq1.push_back(t);
  endtask

  initial begin : drv0
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = 16'd0; req0_b = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (took0 && rq0.size() > 0) rq0.delete(0);
      if (rq0.size() > 0) begin
        req0_valid = 1'b1; req0_op = rq0[0].op; req0_a = rq0[0].a; req0_b = rq0[0].b;
      end else begin
        req0_valid = 1'b0;
      end
    end
  end

  initial begin : drv1
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 16'd0; req1_b = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (took1 && rq1.size() > 0) rq1.delete(0);
      if (rq1.size() > 0) begin
        req1_valid = 1'b1; req1_op = rq1[0].op; req1_a = rq1[0].a; req1_b = rq1[0].b;
      end else begin
        req1_valid = 1'b0;
      end
    end
  end

  // ---------------- model + scoreboard ----------------
  // Expected responses, {err, id, data}, in acceptance order.
  logic [31:0] exp_q[$];
  logic [31:0] rsp_log[$];
  logic [2:0]  cmd_log[$];

  function automatic logic [30:0] resp_of(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    if (op > 3'd4 || (op == 3'd4 && b[15:1] == 15'd0)) return {1'b1, 30'd0};
    case (op)
      3'd3:    return {1'b0, alu_ref(3'd4, a, b), alu_ref(3'd3, a, b)};
      3'd4:    return {1'b0, alu_ref(3'd6, a, b), alu_ref(3'd5, a, b)};
      default: return {1'b0, 15'd0, alu_ref(op, a, b)};
    endcase
  endfunction

  // Model: idle, or busy for an accepted op with m_age cycles since accept;
  // the response is due once m_age reaches m_lat.
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  logic        m_err  = 1'b0;
  int          m_age  = 0;
  int          m_lat  = 0;
  logic [2:0]  m_c1 = 3'd0, m_c2 = 3'd0;
  logic [15:0] m_a = 16'd0, m_b = 16'd0;

  always @(negedge clk) begin : compare
    logic        g, e_r0, e_r1, e_valid;
    logic [2:0]  e_cmd, op;
    logic [15:0] a, b;
    logic [30:0] r;
    cyc++;
    took0 = req0_valid && req0_ready && !reset;
    took1 = req1_valid && req1_ready && !reset;
    if (alu_command != 3'd0) cmd_log.push_back(alu_command);
    if ((alu_command == 3'd5 || alu_command == 3'd6) && alu_B[15:1] == 15'd0) begin
      n_vec++; n_err++;
      $display("FAIL div_by_zero_issued: got cmd %0d with divisor 0 (cycle %0d)", alu_command, cyc);
    end

    g = (req0_valid && req1_valid) ? !m_last : req1_valid;
    if (reset) begin
      e_r0 = 1'b0; e_r1 = 1'b0; e_valid = 1'b0; e_cmd = 3'd0;
    end else begin
      e_r0    = !m_busy && (req0_valid || req1_valid) && !g;
      e_r1    = !m_busy && (req0_valid || req1_valid) && g;
      e_valid = m_busy && (m_age >= m_lat);
      if (m_busy && !m_err && m_age == 1)      e_cmd = m_c1;
      else if (m_busy && m_lat == 3 && m_age == 2) e_cmd = m_c2;
      else                                     e_cmd = 3'd0;
    end
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("rsp_valid", rsp_valid, e_valid);
    chk("busy", busy, reset ? 1'b0 : m_busy);
    chk("alu_command", alu_command, e_cmd);
    chk("alu_A", alu_A, reset ? 16'd0 : m_a);
    chk("alu_B", alu_B, reset ? 16'd0 : m_b);
    if (reset) begin
      chk("reset_rsp_id", rsp_id, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_rsp_err", rsp_err, 0);
    end else if (e_valid && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rsp_unexpected: got id %0d data %0h with no expected response", rsp_id, rsp_data);
      end else begin
        chk("rsp_id", rsp_id, exp_q[0][30]);
        chk("rsp_data", rsp_data, exp_q[0][29:0]);
        chk("rsp_err", rsp_err, exp_q[0][31]);
        if (rsp_ready) exp_q.delete(0);
      end
    end
    if (rsp_valid && rsp_ready && !reset) rsp_log.push_back({rsp_err, rsp_id, rsp_data});

    // advance the model to the state after the next rising edge
    if (reset) begin
      m_busy = 1'b0; m_last = 1'b1; m_a = 16'd0; m_b = 16'd0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        op = g ? req1_op : req0_op;
        a  = g ? req1_a  : req0_a;
        b  = g ? req1_b  : req0_b;
        r  = resp_of(op, a, b);
        m_err  = r[30];
        m_lat  = m_err ? 1 : ((op == 3'd3 || op == 3'd4) ? 3 : 2);
        m_c1   = (op == 3'd4) ? 3'd6 : op;
        m_c2   = (op == 3'd3) ? 3'd4 : 3'd5;
        m_busy = 1'b1; m_age = 1; m_last = g; m_a = a; m_b = b;
        exp_q.push_back({r[30], g, r[29:0]});
      end
    end else if (m_age < m_lat) begin
      m_age++;
    end else if (rsp_ready) begin
      m_busy = 1'b0;
    end
  end

  // ---------------- directed sequences ----------------
  task automatic run_one(input int id, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int exp_lat,
                         input logic [29:0] exp_data, input logic exp_err,
                         input string nm);
    int t0, n;
    logic seen;
    cmd_log.delete();
    push_req(id, op, a, b);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (id == 0) ? req0_ready : req1_ready;
    end
    chk({nm, "_accepted"}, seen, 1'b1);
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = rsp_valid;
    end
    chk({nm, "_rsp_seen"}, seen, 1'b1);
    chk({nm, "_latency"}, cyc - t0, exp_lat);
    chk({nm, "_id"}, rsp_id, id[0]);
    chk({nm, "_data"}, rsp_data, exp_data);
    chk({nm, "_err"}, rsp_err, exp_err);
    n = 0;
    while (busy && n < 20) begin @(negedge clk); #1; n++; end
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int n;
    reset = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_cmd", alu_command, 0);
    chk("reset_ready0", req0_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_one(0, 3'd0, 16'h0006, 16'h0008, 2, 30'd7, 1'b0, "add_r0");
    run_one(1, 3'd3, 16'h0006, 16'h0008, 3, {15'd0, 15'd12}, 1'b0, "mul_r1");
    chk("mul_cmd_count", cmd_log.size(), 2);
    if (cmd_log.size() == 2) begin
      chk("mul_cmd_first", cmd_log[0], 3);
      chk("mul_cmd_second", cmd_log[1], 4);
    end
    run_one(0, 3'd4, 16'h000E, 16'h0004, 3, {15'd3, 15'd1}, 1'b0, "divmod_r0");
    chk("div_cmd_count", cmd_log.size(), 2);
    if (cmd_log.size() == 2) begin
      chk("div_cmd_first", cmd_log[0], 6);
      chk("div_cmd_second", cmd_log[1], 5);
    end
    run_one(1, 3'd4, 16'h000E, 16'h0000, 1, 30'd0, 1'b1, "div0_r1");
    chk("div0_cmd_count", cmd_log.size(), 0);
    run_one(0, 3'd7, 16'h0006, 16'h0008, 1, 30'd0, 1'b1, "illegal_r0");
    chk("illegal_cmd_count", cmd_log.size(), 0);
    run_one(0, 3'd3, 16'h7FFE, 16'h7FFE, 3, {15'h1FFF, 15'h0001}, 1'b0, "mul_max_r0");
    run_one(1, 3'd1, 16'h0014, 16'h0006, 2, 30'd7, 1'b0, "sub_r1");

    // Arbitration: both requesters stream ADDs; last grant was requester 1.
    n = rsp_log.size();
    for (int i = 0; i < 4; i++) begin
      push_req(0, 3'd0, 16'(2 * (i + 1)), 16'h0002);
      push_req(1, 3'd0, 16'(2 * (i + 5)), 16'h0002);
    end
    for (int i = 0; i < 200 && rsp_log.size() < n + 8; i++) @(negedge clk);
    chk("arb_rsp_count", rsp_log.size() - n, 8);
    if (rsp_log.size() >= n + 8) begin
      for (int i = 0; i < 8; i++) chk("arb_rsp_id", rsp_log[n + i][30], i % 2);
      chk("arb_first_data", rsp_log[n][29:0], 30'd2);
      chk("arb_second_data", rsp_log[n + 1][29:0], 30'd6);
    end
    repeat (2) @(negedge clk);

    // Response stall with requester 1 waiting.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    push_req(0, 3'd0, 16'h0010, 16'h0002);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("stall_rsp_seen", rsp_valid, 1);
    push_req(1, 3'd0, 16'h0002, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall_data", rsp_data, 30'd9);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_ready0", req0_ready, 0);
      chk("stall_ready1", req1_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n = rsp_log.size();
    for (int i = 0; i < 30 && rsp_log.size() < n + 2; i++) @(negedge clk);
    chk("stall_after_count", rsp_log.size() - n, 2);
    if (rsp_log.size() >= n + 2) begin
      chk("stall_after_first", rsp_log[n], {2'b00, 30'd9});
      chk("stall_after_second", rsp_log[n + 1], {2'b01, 30'd2});
    end
    repeat (2) @(negedge clk);

    // Reset during EXEC2 of a MUL.
    push_req(1, 3'd3, 16'h0006, 16'h0008);
    n = 0;
    while (alu_command != 3'd4 && n < 30) begin @(negedge clk); #1; n++; end
    chk("rst_reached_exec2", alu_command, 4);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_cmd", alu_command, 0);
    chk("rst_async_A", alu_A, 0);
    chk("rst_async_B", alu_B, 0);
    chk("rst_async_data", rsp_data, 0);
    chk("rst_async_valid", rsp_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    n = rsp_log.size();
    push_req(0, 3'd0, 16'h0004, 16'h0004);
    push_req(1, 3'd0, 16'h0006, 16'h0002);
    for (int i = 0; i < 30 && rsp_log.size() < n + 2; i++) @(negedge clk);
    chk("post_rst_count", rsp_log.size() - n, 2);
    if (rsp_log.size() >= n + 2) begin
      chk("post_rst_first", rsp_log[n], {2'b00, 30'd4});
      chk("post_rst_second", rsp_log[n + 1], {2'b01, 30'd4});
    end
    repeat (3) @(negedge clk);
    chk("final_exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_vec++; n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
